// File: rtl/adder_rr_if.sv
// Request/response bundle for adder_rr_scheduler: NUM_REQ operand channels in, one result channel out.
// A beat moves on a channel at a rising clk edge where its valid and ready are both high; valid never waits on ready.
interface adder_rr_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 32,
    parameter int ID_W    = 2
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ*DATA_W-1:0] req_a;
    logic [NUM_REQ*DATA_W-1:0] req_b;
    logic                      rsp_valid;
    logic                      rsp_ready;
    logic [ID_W-1:0]           rsp_id;
    logic [DATA_W-1:0]         rsp_sum;
    logic                      rsp_carry;

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_sum, rsp_carry
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_sum, rsp_carry
    );
endinterface

// File: rtl/adder_rr_scheduler.sv
// Round-robin arbiter sharing one unsigned adder across NUM_REQ requesters, with a one-entry result register.
// Define ADDER_RR_SAT_EN to saturate rsp_sum to all-ones on carry-out (rsp_carry stays raw).
module adder_rr_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 32,
    parameter int ID_W    = 2
) (
    input  logic            clk,
    input  logic            rst,
    adder_rr_if.slave       bus,
    output logic            dbg_state,
    output logic [ID_W-1:0] dbg_rr_ptr
);
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t            state_q,     state_d;
    logic [ID_W-1:0]   rr_ptr_q,    rr_ptr_d;
    logic [ID_W-1:0]   rsp_id_q,    rsp_id_d;
    logic [DATA_W-1:0] rsp_sum_q,   rsp_sum_d;
    logic              rsp_carry_q, rsp_carry_d;

    logic               can_accept;
    logic               gnt_found;
    logic [ID_W-1:0]    gnt_idx;
    logic [ID_W:0]      cand;
    logic [NUM_REQ-1:0] gnt_onehot;
    logic               req_fire;
    logic [DATA_W-1:0]  op_a;
    logic [DATA_W-1:0]  op_b;
    logic [DATA_W:0]    raw_sum;
    logic [DATA_W-1:0]  sum_res;

    // A full register may still accept when it is draining in the same cycle.
    assign can_accept = (state_q == ST_EMPTY) || bus.rsp_ready;

    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
            if (cand >= (ID_W+1)'(NUM_REQ)) begin
                cand = cand - (ID_W+1)'(NUM_REQ);
            end
            if (!gnt_found && bus.req_valid[cand[ID_W-1:0]]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand[ID_W-1:0];
            end
        end
    end

    // Reset gates the grant so nothing is offered while rst is high.
    always_comb begin
        gnt_onehot = '0;
        if (gnt_found && can_accept && !rst) begin
            gnt_onehot[gnt_idx] = 1'b1;
        end
    end

    assign req_fire = |(bus.req_valid & gnt_onehot);

    assign op_a    = bus.req_a[gnt_idx*DATA_W +: DATA_W];
    assign op_b    = bus.req_b[gnt_idx*DATA_W +: DATA_W];
    assign raw_sum = {1'b0, op_a} + {1'b0, op_b};

`ifdef ADDER_RR_SAT_EN
    assign sum_res = raw_sum[DATA_W] ? {DATA_W{1'b1}} : raw_sum[DATA_W-1:0];
`else
    assign sum_res = raw_sum[DATA_W-1:0];
`endif

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        rsp_id_d    = rsp_id_q;
        rsp_sum_d   = rsp_sum_q;
        rsp_carry_d = rsp_carry_q;
        if (req_fire) begin
            state_d     = ST_FULL;
            rsp_id_d    = gnt_idx;
            rsp_sum_d   = sum_res;
            rsp_carry_d = raw_sum[DATA_W];
            rr_ptr_d    = (gnt_idx == ID_W'(NUM_REQ-1)) ? '0 : gnt_idx + ID_W'(1);
        end else if ((state_q == ST_FULL) && bus.rsp_ready) begin
            state_d = ST_EMPTY;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_EMPTY;
            rr_ptr_q    <= '0;
            rsp_id_q    <= '0;
            rsp_sum_q   <= '0;
            rsp_carry_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            rsp_id_q    <= rsp_id_d;
            rsp_sum_q   <= rsp_sum_d;
            rsp_carry_q <= rsp_carry_d;
        end
    end

    assign bus.req_ready = gnt_onehot;
    assign bus.rsp_valid = (state_q == ST_FULL);
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_sum   = rsp_sum_q;
    assign bus.rsp_carry = rsp_carry_q;

    assign dbg_state  = state_q;
    assign dbg_rr_ptr = rr_ptr_q;
endmodule
